pll_lock_rst_seq: RTL and testbench
===================================

Name: pll_lock_rst_seq

Overview:
- Reset sequencer directly downstream of the PLL.
- Consumes the PLL's asynchronous lock output and produces staged reset releases for the FFT core and application logic. It also drives the PLL's own reset.
- Runs on the free-running PLL reference clock (the 27 MHz board clock), not on a PLL output, so it keeps operating while lock is lost.
- Re-sequences on lock loss and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2: flops in the pll_lock synchroniser (minimum 2).
- PLL_RST_CYC, 64: cycles pll_rst is held high per reset pulse.
- TIMEOUT_CYC, 65536: cycles allowed in WAIT_LOCK before the PLL is re-reset.
- STABLE_CYC, 1024: consecutive cycles synchronised lock must stay high before release.
- RELEASE_GAP, 16: cycles between rst_core_n release and rst_app_n release.
- CNT_W, 8: width of lost_cnt.

Ports:
- clk  in  1  reference clock (PLL clkin).
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock; asynchronous to clk.
- sw_rst  in  1  synchronous software re-sequence request, level sampled.
- pll_rst  out  1  reset to PLL, active high.
- rst_core_n  out  1  FFT core reset, active low.
- rst_app_n  out  1  application reset, active low.
- lock_ok  out  1  high only in RUN.
- lost_cnt  out  CNT_W  saturating count of lock-loss events.
- state_dbg  out  3  current state encoding.

Behaviour:
- rst_n low, asynchronously:
  - state=PLL_RST, pll_rst=1, rst_core_n=0, rst_app_n=0, lock_ok=0, lost_cnt=0, all counters 0, synchroniser flops 0.
  - All outputs are registered.
- lock_s is pll_lock after SYNC_STAGES flops. Only lock_s is used internally.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, REL_CORE=3, RUN=4.
- One shared counter cnt is cleared on every state transition.
- PLL_RST:
  - pll_rst=1.
  - After PLL_RST_CYC cycles, go to WAIT_LOCK; pll_rst=0 from the same edge.
- WAIT_LOCK:
  - lock_s=1: go to STABLE.
  - Else when cnt reaches TIMEOUT_CYC-1: go to PLL_RST (retry; see Optional Feature).
- STABLE:
  - lock_s=0: go back to WAIT_LOCK, no timeout penalty, cnt cleared.
  - After STABLE_CYC consecutive cycles with lock_s=1: go to REL_CORE and set rst_core_n=1.
- REL_CORE:
  - After RELEASE_GAP cycles: go to RUN and set rst_app_n=1 and lock_ok=1.
- RUN: hold until lock loss or sw_rst.
- Lock loss (lock_s=0 in REL_CORE or RUN):
  - Next edge: rst_core_n=0, rst_app_n=0, lock_ok=0, go to WAIT_LOCK.
  - lost_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - Lock loss in STABLE or WAIT_LOCK does not increment lost_cnt.
- sw_rst=1:
  - In any state other than PLL_RST: next edge deasserts all releases and goes to PLL_RST with pll_rst=1.
  - sw_rst takes priority over lock loss in the same cycle; lost_cnt is not incremented.
  - sw_rst held high keeps the block in PLL_RST; the PLL_RST_CYC count restarts while it is high.
- Latency: a pll_lock rise followed by steady lock gives rst_core_n rising exactly SYNC_STAGES+STABLE_CYC+1 cycles after the first clk edge sampling pll_lock=1. rst_app_n rises RELEASE_GAP cycles after rst_core_n.
- Reset ordering:
  - Release is always rst_core_n before rst_app_n.
  - Assertion is simultaneous.
  - rst_app_n is never 1 while rst_core_n is 0.
- rst_n asserted mid-sequence returns everything to reset values immediately. This includes lost_cnt.

Optional Feature:
- Macro: PLL_LOCK_RETRY_EN.
- Defined: a WAIT_LOCK timeout returns to PLL_RST and re-pulses pll_rst for PLL_RST_CYC cycles, repeating indefinitely.
- Undefined:
  - No timeout; WAIT_LOCK waits forever and the timeout compare logic is not built.
  - pll_rst pulses only after rst_n or sw_rst.

Test Plan (PLL_RST_CYC=8, TIMEOUT_CYC=256, STABLE_CYC=16, RELEASE_GAP=4, SYNC_STAGES=2):
- Power-up: rst_n low 5 cycles, then high; pll_lock rises at cycle 20 and stays high → pll_rst high 8 cycles after rst_n release; rst_core_n rises 19 cycles after pll_lock is first sampled; rst_app_n and lock_ok rise 4 cycles later; lost_cnt=0.
- Glitchy lock: pll_lock high 10 cycles, low 3, then steady → no release during the glitch; STABLE restarts; rst_core_n rises 19 cycles after the final rise.
- Lock loss in RUN: drop pll_lock for 5 cycles → rst_core_n and rst_app_n fall together 3 cycles after the drop; lost_cnt=1; re-release follows the same 19+4 cycle timing.
- Timeout with PLL_LOCK_RETRY_EN defined: pll_lock held 0 → pll_rst re-pulses for 8 cycles every 264 cycles. With the macro undefined: pll_rst stays 0 after the first pulse.
- sw_rst in RUN coinciding with a lock drop → next edge: state_dbg=0, pll_rst=1, resets asserted, lost_cnt unchanged.
- Saturation: force 300 lock-loss events with CNT_W=8 → lost_cnt holds 255.

Source files
------------

// File: rtl/pll_lock_rst_seq.sv
// Reset sequencer behind the PLL: synchronises lock, pulses pll_rst, then releases core before app.
// Optional build macro PLL_LOCK_RETRY_EN: re-pulse pll_rst when lock does not arrive within TIMEOUT_CYC.
module pll_lock_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int PLL_RST_CYC = 64,
  parameter int TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC  = 1024,
  parameter int RELEASE_GAP = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             sw_rst,
  output logic             pll_rst,
  output logic             rst_core_n,
  output logic             rst_app_n,
  output logic             lock_ok,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [2:0]       state_dbg
);

  // Shared counter sized for the longest interval it ever has to reach.
  localparam int M1 = (PLL_RST_CYC > STABLE_CYC + 1) ? PLL_RST_CYC : STABLE_CYC + 1;
  localparam int M2 = (M1 > RELEASE_GAP) ? M1 : RELEASE_GAP;
  localparam int M3 = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
  localparam int CW = $clog2(M3 + 1);

  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYC);
  localparam logic [CW-1:0] RG_LAST = CW'(RELEASE_GAP - 1);
`ifdef PLL_LOCK_RETRY_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_CORE  = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                 st, st_nx;
  logic [SYNC_STAGES-1:0] sy;
  logic                   lock_s;
  logic [CW-1:0]          cnt;
  logic                   cnt_clr, cnt_en, lost_inc;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sy <= '0;
    else        sy <= {sy[SYNC_STAGES-2:0], pll_lock};

  assign lock_s = sy[SYNC_STAGES-1];

  always_comb begin
    st_nx    = st;
    lost_inc = 1'b0;
    if (sw_rst) st_nx = S_PLL_RST;
    else begin
      case (st)
        S_PLL_RST:   if (cnt == PR_LAST) st_nx = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) st_nx = S_STABLE;
`ifdef PLL_LOCK_RETRY_EN
          else if (cnt == TO_LAST) st_nx = S_PLL_RST;
`endif
        end
        S_STABLE: begin
          if (!lock_s)              st_nx = S_WAIT_LOCK;
          else if (cnt == ST_LAST) st_nx = S_REL_CORE;
        end
        S_REL_CORE: begin
          if (!lock_s) begin
            st_nx    = S_WAIT_LOCK;
            lost_inc = 1'b1;
          end else if (cnt == RG_LAST) st_nx = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            st_nx    = S_WAIT_LOCK;
            lost_inc = 1'b1;
          end
        end
        default: st_nx = S_PLL_RST;
      endcase
    end
  end

  // sw_rst also clears the count so a held request keeps restarting the pll_rst pulse.
  assign cnt_clr = sw_rst || (st_nx != st);
`ifdef PLL_LOCK_RETRY_EN
  assign cnt_en  = (st != S_RUN);
`else
  assign cnt_en  = (st != S_RUN) && (st != S_WAIT_LOCK);
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= S_PLL_RST;
      cnt <= '0;
    end else begin
      st <= st_nx;
      if (cnt_clr)     cnt <= '0;
      else if (cnt_en) cnt <= cnt + 1'b1;
    end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pll_rst    <= 1'b1;
      rst_core_n <= 1'b0;
      rst_app_n  <= 1'b0;
      lock_ok    <= 1'b0;
      lost_cnt   <= '0;
    end else begin
      pll_rst    <= (st_nx == S_PLL_RST);
      rst_core_n <= (st_nx == S_REL_CORE) || (st_nx == S_RUN);
      rst_app_n  <= (st_nx == S_RUN);
      lock_ok    <= (st_nx == S_RUN);
      if (lost_inc && (lost_cnt != '1)) lost_cnt <= lost_cnt + 1'b1;
    end

  assign state_dbg = st;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Randomised and directed bench for pll_lock_rst_seq against a phase/duration reference model.
module tb_pll_lock_rst_seq;
  localparam int SYNC = 2, PRC = 8, TOC = 256, STC = 16, RG = 4, CW = 8;
  localparam int PH_PLLR = 0, PH_WAIT = 1, PH_STB = 2, PH_REL = 3, PH_RUN = 4;

  logic clk = 1'b0, rst_n = 1'b1, pll_lock = 1'b0, sw_rst = 1'b0;
  logic pll_rst, rst_core_n, rst_app_n, lock_ok;
  logic [CW-1:0] lost_cnt;
  logic [2:0] state_dbg;

  int n_chk = 0, n_err = 0;
  int m_ph, m_age, m_lost;
  bit m_q[$];

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYC(PRC), .TIMEOUT_CYC(TOC),
    .STABLE_CYC(STC), .RELEASE_GAP(RG), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_rst(sw_rst),
    .pll_rst(pll_rst), .rst_core_n(rst_core_n), .rst_app_n(rst_app_n),
    .lock_ok(lock_ok), .lost_cnt(lost_cnt), .state_dbg(state_dbg)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges each phase lasts before it advances on its own (0 = open-ended).
  function automatic int dur(int ph);
    case (ph)
      PH_PLLR: return PRC;
`ifdef PLL_LOCK_RETRY_EN
      PH_WAIT: return TOC;
`endif
      PH_STB:  return STC + 1;
      PH_REL:  return RG;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = PH_PLLR; m_age = 0; m_lost = 0;
    m_q = {};
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ls;
    int nx;
    if (!rst_n) begin model_reset(); return; end
    ls = m_q.pop_front();
    m_q.push_back(pll_lock);
    nx = m_ph;
    if (sw_rst) nx = PH_PLLR;
    else if (m_ph >= PH_STB && !ls) begin
      nx = PH_WAIT;
      if (m_ph >= PH_REL && m_lost < 255) m_lost++;
    end else if (m_ph == PH_WAIT && ls) nx = PH_STB;
    else if (dur(m_ph) != 0 && m_age + 1 >= dur(m_ph))
      nx = (m_ph == PH_WAIT) ? PH_PLLR : m_ph + 1;
    m_age = (nx != m_ph || sw_rst) ? 0 : m_age + 1;
    m_ph = nx;
  endtask

  task automatic cmp(string tag);
    logic [14:0] e;
    e = {m_ph == PH_PLLR, m_ph >= PH_REL, m_ph == PH_RUN, m_ph == PH_RUN, 8'(m_lost), 3'(m_ph)};
    chk(tag, {17'd0, pll_rst, rst_core_n, rst_app_n, lock_ok, lost_cnt, state_dbg}, {17'd0, e});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp("model");
  endtask

  // Counts cycles until the chosen release output reaches val; a miss is reported as a failure.
  task automatic wait_rel(string tag, bit core, logic val, int max, output int n);
    n = 0;
    do begin cyc(); n++; end
    while (((core ? rst_core_n : rst_app_n) !== val) && n < max);
    if ((core ? rst_core_n : rst_app_n) !== val) chk({tag, "_timeout"}, core ? rst_core_n : rst_app_n, val);
  endtask

  task automatic async_rst();
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    chk("async_rst", {pll_rst, rst_core_n, rst_app_n, lock_ok, lost_cnt, state_dbg}, {1'b1, 3'b000, 8'd0, 3'd0});
  endtask

  initial begin
    int n, hi, rises, r1, r2, lost0;
    logic prev;
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk("rst_vals", {pll_rst, rst_core_n, rst_app_n, lock_ok, lost_cnt, state_dbg}, {1'b1, 3'b000, 8'd0, 3'd0});
    repeat (5) cyc();
    rst_n = 1'b1;

    // Power-up
    n = 0;
    do begin cyc(); n++; end while (pll_rst === 1'b1 && n < 50);
    chk("pllrst_len", n, PRC);
    repeat (20 - PRC) cyc();
    pll_lock = 1'b1;
    wait_rel("pu_core", 1'b1, 1'b1, 60, n);
    chk("pu_core_lat", n - 1, SYNC + STC + 1);
    wait_rel("pu_app", 1'b0, 1'b1, 20, n);
    chk("pu_app_gap", n, RG);
    chk("pu_lock_ok", lock_ok, 1'b1);
    chk("pu_lost", lost_cnt, 0);

    // Glitchy lock from a fresh PLL reset
    pll_lock = 1'b0; sw_rst = 1'b1; cyc(); sw_rst = 1'b0;
    repeat (PRC + 2) cyc();
    pll_lock = 1'b1; repeat (10) cyc();
    chk("gl_no_rel", rst_core_n, 1'b0);
    pll_lock = 1'b0; repeat (3) cyc();
    pll_lock = 1'b1;
    wait_rel("gl_core", 1'b1, 1'b1, 60, n);
    chk("gl_core_lat", n - 1, SYNC + STC + 1);
    wait_rel("gl_app", 1'b0, 1'b1, 20, n);

    // Lock loss in RUN
    pll_lock = 1'b0;
    wait_rel("ll_core", 1'b1, 1'b0, 10, n);
    chk("ll_fall_lat", n, 3);
    chk("ll_app_together", rst_app_n, 1'b0);
    chk("ll_lost", lost_cnt, 1);
    repeat (5 - n) cyc();
    pll_lock = 1'b1;
    wait_rel("ll_core_re", 1'b1, 1'b1, 60, n);
    chk("ll_core_lat", n - 1, SYNC + STC + 1);
    wait_rel("ll_app_re", 1'b0, 1'b1, 20, n);
    chk("ll_app_gap", n, RG);

    // Lock never arrives
    pll_lock = 1'b0; sw_rst = 1'b1; cyc(); sw_rst = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (pll_rst === 1'b1 && n < 50);
    hi = 0; rises = 0; r1 = 0; r2 = 0; prev = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      cyc();
      if (pll_rst === 1'b1) hi++;
      if (pll_rst === 1'b1 && !prev) begin
        rises++;
        if (rises == 1) r1 = i;
        if (rises == 2) r2 = i;
      end
      prev = pll_rst;
    end
`ifdef PLL_LOCK_RETRY_EN
    chk("retry_high_cyc", hi, 2 * PRC);
    chk("retry_first", r1, TOC);
    chk("retry_period", r2 - r1, TOC + PRC);
`else
    chk("no_retry_high", hi, 0);
    chk("no_retry_rises", rises, 0);
`endif

    // sw_rst coinciding with a lock drop in RUN
    pll_lock = 1'b1;
    wait_rel("sw_core", 1'b1, 1'b1, 80, n);
    wait_rel("sw_app", 1'b0, 1'b1, 20, n);
    lost0 = lost_cnt;
    pll_lock = 1'b0; cyc(); cyc();
    sw_rst = 1'b1; cyc(); sw_rst = 1'b0;
    chk("sw_state", state_dbg, 3'd0);
    chk("sw_pllrst", pll_rst, 1'b1);
    chk("sw_resets", {rst_core_n, rst_app_n, lock_ok}, 3'b000);
    chk("sw_lost", lost_cnt, lost0);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      wait_rel("sat_up", 1'b1, 1'b1, 80, n);
      pll_lock = 1'b0;
      wait_rel("sat_dn", 1'b1, 1'b0, 10, n);
    end
    chk("sat_lost", lost_cnt, 255);

    // Mid-sequence reset clears everything including lost_cnt
    pll_lock = 1'b1;
    wait_rel("mid_core", 1'b1, 1'b1, 80, n);
    async_rst();
    cyc(); cyc();
    rst_n = 1'b1;

    // Random traffic
    for (int seg = 0; seg < 120; seg++) begin
      int len, r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_rst();
        repeat ($urandom_range(1, 3)) cyc();
        rst_n = 1'b1;
      end else if (r < 10) begin
        sw_rst = 1'b1;
        repeat ($urandom_range(1, 3)) cyc();
        sw_rst = 1'b0;
      end
      pll_lock = ($urandom_range(0, 99) < 70);
      len = pll_lock ? $urandom_range(1, 40) : $urandom_range(1, 12);
      repeat (len) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
